// File: rtl/updown_step_counter.sv
// Up/down counter with programmable step and range 0..limit, wrap or saturate, clear/load, and a registered terminal-count pulse.
// Define UPDOWN_STEP_COUNTER_PRESCALE_EN to add the prescale_i port and a PRESCALE_W-bit enable divider.
module updown_step_counter #(
    parameter int unsigned WIDTH = 8
`ifdef UPDOWN_STEP_COUNTER_PRESCALE_EN
    , parameter int unsigned PRESCALE_W = 4
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  dir_i,
    input  logic                  sat_i,
    input  logic [WIDTH-1:0]      step_i,
    input  logic [WIDTH-1:0]      limit_i,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic [WIDTH-1:0]      load_val_i,
`ifdef UPDOWN_STEP_COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale_i,
`endif
    output logic [WIDTH-1:0]      count_o,
    output logic                  tc_o,
    output logic                  at_zero_o,
    output logic                  at_limit_o
);

    localparam int unsigned W1 = WIDTH + 1;

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] eff_step;
    logic [W1-1:0]    up_sum;
    logic [W1-1:0]    lim_p1;
    logic             tick;

`ifdef UPDOWN_STEP_COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] div_q, div_d;

    // A prescale value lowered below the divider still ticks on the next enabled edge.
    assign tick = (div_q >= prescale_i);

    always_comb begin
        div_d = div_q;
        if (clr_i || load_i) begin
            div_d = '0;
        end else if (en_i) begin
            div_d = tick ? '0 : div_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Sums kept one bit wider so limit+1 and count+step never lose a carry.
    assign eff_step = (step_i > limit_i) ? limit_i : step_i;
    assign up_sum   = W1'(count_q) + W1'(eff_step);
    assign lim_p1   = W1'(limit_i) + W1'(1);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = (load_val_i > limit_i) ? limit_i : load_val_i;
        end else if (en_i && tick && (step_i != '0)) begin
            tc_d = 1'b1;
            // limit 0 pins the count at 0; an out-of-range count snaps back to limit.
            if ((limit_i == '0) || (count_q > limit_i)) begin
                count_d = limit_i;
            end else if (dir_i) begin
                if (up_sum <= W1'(limit_i)) begin
                    count_d = WIDTH'(up_sum);
                    tc_d    = 1'b0;
                end else begin
                    count_d = sat_i ? limit_i : WIDTH'(up_sum - lim_p1);
                end
            end else begin
                if (eff_step <= count_q) begin
                    count_d = count_q - eff_step;
                    tc_d    = 1'b0;
                end else begin
                    count_d = sat_i ? '0 : WIDTH'(W1'(count_q) + lim_p1 - W1'(eff_step));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count_o    = count_q;
    assign tc_o       = tc_q;
    assign at_zero_o  = (count_q == '0);
    assign at_limit_o = (count_q == limit_i);

endmodule
